// File: rtl/lif_array_if.sv
// Bus bundle for the leaky integrate-and-fire array.
// Covers step control, per-neuron currents, neuron configuration and registered results.
interface lif_array_if #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned REFRAC_W  = 3
);
    logic                          en;
    logic [N_NEURONS*WIDTH-1:0]    current;
    logic [WIDTH-1:0]              threshold;
    logic [2:0]                    leak_shift;
    logic [REFRAC_W-1:0]           refrac_cycles;
    logic                          reset_mode;
    logic                          clr_count;
    logic [N_NEURONS*WIDTH-1:0]    state;
    logic [N_NEURONS-1:0]          spike;
    logic [15:0]                   total_spikes;

    modport master (
        output en, current, threshold, leak_shift, refrac_cycles, reset_mode, clr_count,
        input  state, spike, total_spikes
    );

    modport slave (
        input  en, current, threshold, leak_shift, refrac_cycles, reset_mode, clr_count,
        output state, spike, total_spikes
    );
endinterface

// File: rtl/lif_array.sv
// Array of N leaky integrate-and-fire neurons stepped in parallel on each enabled clock,
// with shift leak, saturation, zero/subtract reset, refractory hold and a global spike counter.
module lif_array #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned REFRAC_W  = 3
) (
    input  logic        clk,
    input  logic        rst,
    lif_array_if.slave  bus
);
    localparam int unsigned CNT_W = 16;

    logic [N_NEURONS*WIDTH-1:0]    state_q, state_d;
    logic [N_NEURONS*REFRAC_W-1:0] refrac_q, refrac_d;
    logic [N_NEURONS-1:0]          spike_q, spike_d;
    logic [CNT_W-1:0]              total_q, total_d;
    logic [CNT_W-1:0]              pop;

    logic [WIDTH-1:0]              s, leak, s_leaked, cur, sat;
    logic [WIDTH:0]                sum;

    // Per-neuron next-step computation and popcount of the new spike vector
    always_comb begin
        state_d  = state_q;
        refrac_d = refrac_q;
        spike_d  = '0;
        pop      = '0;
        s        = '0;
        leak     = '0;
        s_leaked = '0;
        cur      = '0;
        sat      = '0;
        sum      = '0;
        if (bus.en) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                s        = state_q[i*WIDTH +: WIDTH];
                leak     = (bus.leak_shift == 3'd0) ? '0 : (s >> bus.leak_shift);
                s_leaked = s - leak;
                cur      = bus.current[i*WIDTH +: WIDTH];
                sum      = {1'b0, s_leaked} + {1'b0, cur};
                sat      = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                if (refrac_q[i*REFRAC_W +: REFRAC_W] != '0) begin
                    state_d[i*WIDTH +: WIDTH]        = s_leaked;
                    refrac_d[i*REFRAC_W +: REFRAC_W] = refrac_q[i*REFRAC_W +: REFRAC_W] - REFRAC_W'(1);
                end else if ((bus.threshold != '0) && (sat >= bus.threshold)) begin
                    spike_d[i]                       = 1'b1;
                    state_d[i*WIDTH +: WIDTH]        = bus.reset_mode ? (sat - bus.threshold) : '0;
                    refrac_d[i*REFRAC_W +: REFRAC_W] = bus.refrac_cycles;
                    pop                              = pop + CNT_W'(1);
                end else begin
                    state_d[i*WIDTH +: WIDTH]        = sat;
                end
            end
        end
    end

    // Clear loads this step's spikes so a coincident spike is still counted
    always_comb begin
        total_d = total_q;
        if (bus.clr_count)
            total_d = bus.en ? pop : '0;
        else if (bus.en)
            total_d = total_q + pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= '0;
            refrac_q <= '0;
            spike_q  <= '0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            refrac_q <= refrac_d;
            spike_q  <= spike_d;
            total_q  <= total_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.spike        = spike_q;
    assign bus.total_spikes = total_q;
endmodule

// File: tb/tb_lif_array.sv
// Scoreboard bench for lif_array: an integer reference model queues expected outputs per
// step, popped after the edge; directed checks cover the documented scenarios.
module tb_lif_array;
    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
    localparam int unsigned R = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lif_array_if #(.N_NEURONS(N), .WIDTH(W), .REFRAC_W(R)) bus ();
    lif_array #(.N_NEURONS(N), .WIDTH(W), .REFRAC_W(R)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [N*W-1:0] st;
        logic [N-1:0]   sp;
        logic [15:0]    tot;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    int          m_state [N];
    int          m_ref   [N];
    logic [15:0] m_total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0;
            m_ref[i]   = 0;
        end
        m_total = '0;
        exp_q.delete();
    endtask

    // Reference model of one edge using the inputs currently driven
    task automatic model_push();
        exp_t e;
        int   pop, s, lk, n, thr, ls;
        pop = 0;
        e.sp = '0;
        thr = int'(bus.threshold);
        ls  = int'(bus.leak_shift);
        for (int i = 0; i < N; i++) begin
            if (bus.en) begin
                s  = m_state[i];
                lk = (ls == 0) ? 0 : (s >> ls);
                if (m_ref[i] != 0) begin
                    m_state[i] = s - lk;
                    m_ref[i]   = m_ref[i] - 1;
                end else begin
                    n = s - lk + int'(bus.current[i*W +: W]);
                    if (n > 255) n = 255;
                    if (thr != 0 && n >= thr) begin
                        e.sp[i]    = 1'b1;
                        m_state[i] = bus.reset_mode ? n - thr : 0;
                        m_ref[i]   = int'(bus.refrac_cycles);
                        pop++;
                    end else begin
                        m_state[i] = n;
                    end
                end
            end
            e.st[i*W +: W] = 8'(m_state[i]);
        end
        if (bus.clr_count) m_total = bus.en ? 16'(pop) : 16'd0;
        else if (bus.en)   m_total = m_total + 16'(pop);
        e.tot = m_total;
        exp_q.push_back(e);
    endtask

    task automatic do_step();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("state", 64'(bus.state), 64'(e.st));
            check("spike", 64'(bus.spike), 64'(e.sp));
            check("total", 64'(bus.total_spikes), 64'(e.tot));
        end
    endtask

    // Asserted between edges so the zeroing must be asynchronous
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_spike", 64'(bus.spike), 64'd0);
        check("rst_total", 64'(bus.total_spikes), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setup(input logic [7:0] thr, input logic [2:0] ls,
                         input logic [2:0] rc, input logic rm, input logic [7:0] cur);
        bus.threshold     = thr;
        bus.leak_shift    = ls;
        bus.refrac_cycles = rc;
        bus.reset_mode    = rm;
        bus.current       = {N{cur}};
        bus.en            = 1'b1;
        bus.clr_count     = 1'b0;
    endtask

    logic [7:0] st_a [4];

    initial begin
        rst = 1'b1;
        setup(8'd0, 3'd0, 3'd0, 1'b0, 8'd0);
        bus.en = 1'b0;
        model_reset();
        #1;
        check("init_state", 64'(bus.state), 64'd0);
        check("init_total", 64'(bus.total_spikes), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Integrate and fire with zero reset
        setup(8'd100, 3'd0, 3'd0, 1'b0, 8'd30);
        st_a = '{8'd30, 8'd60, 8'd90, 8'd0};
        for (int k = 0; k < 4; k++) begin
            do_step();
            check("s1_state0", 64'(bus.state[7:0]), 64'(st_a[k]));
        end
        check("s1_spike", 64'(bus.spike), 64'hf);
        check("s1_total", 64'(bus.total_spikes), 64'd4);

        // Gating holds state and count, spike drops
        bus.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            do_step();
            check("gate_spike", 64'(bus.spike), 64'd0);
            check("gate_total", 64'(bus.total_spikes), 64'd4);
        end
        bus.clr_count = 1'b1;
        do_step();
        check("clr_total", 64'(bus.total_spikes), 64'd0);
        bus.clr_count = 1'b0;
        bus.en = 1'b1;
        do_step();
        do_step();
        do_reset();

        // Subtract reset
        setup(8'd100, 3'd0, 3'd0, 1'b1, 8'd30);
        st_a = '{8'd30, 8'd60, 8'd90, 8'd20};
        for (int k = 0; k < 4; k++) begin
            do_step();
            check("s2_state0", 64'(bus.state[7:0]), 64'(st_a[k]));
        end
        check("s2_spike", 64'(bus.spike), 64'hf);
        do_step();
        check("s2_step5", 64'(bus.state[7:0]), 64'd50);
        do_reset();

        // Leak from a preload of 90 on neuron 0
        setup(8'd0, 3'd1, 3'd0, 1'b0, 8'd0);
        bus.current = 32'd90;
        do_step();
        bus.current = '0;
        st_a = '{8'd45, 8'd23, 8'd12, 8'd6};
        for (int k = 0; k < 4; k++) begin
            do_step();
            check("leak_state0", 64'(bus.state[7:0]), 64'(st_a[k]));
            check("leak_spike", 64'(bus.spike), 64'd0);
        end
        do_reset();

        // Saturation
        setup(8'd0, 3'd0, 3'd0, 1'b0, 8'd200);
        st_a = '{8'd200, 8'd255, 8'd255, 8'd255};
        for (int k = 0; k < 3; k++) begin
            do_step();
            check("sat_state0", 64'(bus.state[7:0]), 64'(st_a[k]));
        end
        check("sat_spike", 64'(bus.spike), 64'd0);
        do_reset();

        // Refractory: spikes on steps 1, 4, 7
        setup(8'd100, 3'd0, 3'd2, 1'b0, 8'd100);
        for (int k = 1; k <= 7; k++) begin
            do_step();
            check("refr_spike", 64'(bus.spike), (k % 3 == 1) ? 64'hf : 64'd0);
            check("refr_state", 64'(bus.state), 64'd0);
        end
        do_reset();

        // Randomised steps against the model, including clear coinciding with spikes
        for (int k = 0; k < 80; k++) begin
            bus.en            = ($urandom_range(0, 7) != 0);
            bus.current       = $urandom;
            bus.threshold     = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            bus.leak_shift    = 3'($urandom_range(0, 7));
            bus.refrac_cycles = 3'($urandom_range(0, 7));
            bus.reset_mode    = 1'($urandom_range(0, 1));
            bus.clr_count     = ($urandom_range(0, 9) == 0);
            do_step();
        end

        // Mid-run asynchronous reset
        setup(8'd100, 3'd0, 3'd0, 1'b0, 8'd30);
        do_step();
        do_step();
        do_reset();
        do_step();
        check("post_rst_state0", 64'(bus.state[7:0]), 64'd30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/lif_array.md
# lif_array

Parametrised array of leaky integrate-and-fire neurons that updates N independent neurons in parallel, one step per enabled clock. Each neuron supports:
- a shift-based leak
- a saturating membrane potential
- a configurable threshold
- zero or subtract reset after a spike
- a refractory period

A global spike event counter sits alongside the array. The block is the next-generation neuron core behind the Tiny Tapeout top-level wrapper. It replaces the single fixed neuron with a configurable multi-channel array.

## Interface
Parameters:
- N_NEURONS, 4, number of neurons (1..8)
- WIDTH, 8, membrane potential and input current width (4..16)
- REFRAC_W, 3, refractory counter width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  step enable; one neuron time-step per cycle with en=1
- current  input  N_NEURONS*WIDTH  per-neuron unsigned input current, neuron i at [i*WIDTH +: WIDTH]
- threshold  input  WIDTH  shared firing threshold, unsigned; 0 disables firing
- leak_shift  input  3  leak = state >> leak_shift; 0 means no leak
- refrac_cycles  input  REFRAC_W  steps a neuron ignores current after a spike
- reset_mode  input  1  0: state to zero on spike; 1: subtract threshold
- clr_count  input  1  synchronous clear of total_spikes
- state  output  N_NEURONS*WIDTH  registered membrane potentials
- spike  output  N_NEURONS  registered one-step spike flags
- total_spikes  output  16  wrapping count of all spikes since reset/clear

## Operation
- Reset (rst=1, asynchronous):
  - state, spike, total_spikes and all internal refractory counters go to 0.
  - This holds regardless of en or mid-step activity.
- en=0:
  - state and refractory counters hold.
  - spike goes to 0.
  - total_spikes holds, except when clr_count=1.
- en=1, per neuron i, with s = state[i] and leak = (leak_shift==0) ? 0 : s >> leak_shift:
  - Refractory (refrac_cnt[i] != 0):
    - state[i] <= s - leak.
    - refrac_cnt[i] decrements.
    - spike[i] <= 0.
    - current[i] is ignored.
  - Active (refrac_cnt[i] == 0):
    - Compute n = (s - leak) + current[i] in WIDTH+1 bits.
    - Saturate n to 2^WIDTH-1.
    - If threshold != 0 and n >= threshold:
      - spike[i] <= 1.
      - state[i] <= reset_mode ? n - threshold : 0.
      - refrac_cnt[i] <= refrac_cycles.
    - Otherwise: spike[i] <= 0 and state[i] <= n.
- Subtraction never underflows, because leak <= s and threshold <= n.
- Saturation applies before the threshold compare.
- total_spikes:
  - Each enabled step adds the popcount of the new spike vector; the counter wraps modulo 2^16.
  - clr_count=1 loads the popcount of the same step, so a spike in that cycle is not lost; with en=0 it loads 0.
- Control inputs (threshold, leak_shift, refrac_cycles, reset_mode) are sampled every step. A change takes effect on the next enabled edge.
- refrac_cycles=0: no refractory period; a neuron may spike on consecutive steps.

## Timing
- Latency:
  - Inputs sampled on the rising edge where en=1.
  - state, spike and total_spikes are valid immediately after that edge.
  - One-step latency, no pipeline.
- spike is a one-cycle pulse per spiking step. With en held high and refrac_cycles=0, a neuron can hold spike=1 continuously.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset deassertion: the first step occurs on the first edge with rst=0 and en=1.

## Test plan
Common setup: N_NEURONS=4, WIDTH=8, REFRAC_W=3.
- **Integrate/fire, zero reset:** leak_shift=0, threshold=100, refrac_cycles=0, reset_mode=0, current=30 on all neurons, en=1.
  - state goes 30, 60, 90, 0.
  - spike=4'b1111 after step 4.
  - total_spikes=4.
- **Subtract reset:** same stimulus with reset_mode=1.
  - state goes 30, 60, 90, 20 with spike after step 4.
  - Step 5 state is 50.
- **Leak:** threshold=0, leak_shift=1, neuron 0 preloaded to 90 via current, then current=0.
  - state goes 45, 23, 12, 6.
  - spike stays 0.
- **Saturation:** threshold=0, leak_shift=0, current=200.
  - state goes 200, 255, 255.
  - No spike.
- **Refractory:** threshold=100, current=100, refrac_cycles=2, reset_mode=0, leak_shift=0.
  - Spike on steps 1, 4, 7.
  - state=0 in between, with current ignored.
- **Gating, clear and reset:** run the first scenario, drop en for 5 cycles (state and total_spikes hold, spike=0), pulse clr_count, then assert rst mid-run.
  - After clr_count: total_spikes=0.
  - rst: all outputs 0 asynchronously, before the next edge.
